vs_sci_reader: RTL

SCI register read master for the VS1003 decoder, complementing the existing SCI/SDI write path that drives o_SI/o_SCK/o_XCS. On a request it issues the SCI READ opcode (0x03) and a register address, then shifts in the 16-bit register value from the decoder's SO pin. Typical consumers are the DECODE_TIME readout (0x4) for the seven-segment display and the HDAT0/HDAT1 status registers (0x8/0x9). The top level muxes the SPI pins between this block and the writer using o_busy.

---
 rtl/vs_sci_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vs_sci_reader.sv
// SCI register read master for the VS1003: sends READ (0x03) + address, shifts in 16 bits from SO.
// Optional DREQ wait timeout is built only when SCI_READ_TIMEOUT_EN is defined.
module vs_sci_reader #(
  parameter int CLK_DIV        = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_addr,
  input  logic        i_DREQ,
  input  logic        i_SO,
  output logic        o_SI,
  output logic        o_SCK,
  output logic        o_XCS,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rdata,
  output logic        o_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DREQ = 3'd1;
  localparam logic [2:0] S_CS_SETUP  = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_CS_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

  logic [2:0]  state_reg;
  logic [7:0]  cnt_reg;
  logic [4:0]  bit_cnt_reg;
  logic [15:0] tx_reg;
  logic [15:0] rx_reg;
  logic [15:0] rdata_reg;
  logic        sck_reg;
  logic        xcs_reg;
  logic        si_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        timeout_reg;
  logic        dreq_meta_reg;
  logic        dreq_sync_reg;

`ifdef SCI_READ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dreq_meta_reg <= 1'b0;
      dreq_sync_reg <= 1'b0;
    end else begin
      dreq_meta_reg <= i_DREQ;
      dreq_sync_reg <= dreq_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      bit_cnt_reg <= 5'd0;
      tx_reg      <= 16'h0000;
      rx_reg      <= 16'h0000;
      rdata_reg   <= 16'h0000;
      sck_reg     <= 1'b0;
      xcs_reg     <= 1'b1;
      si_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
`ifdef SCI_READ_TIMEOUT_EN
      to_cnt_reg  <= '0;
`endif
    end else begin
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            tx_reg    <= {8'h03, 4'h0, i_addr};
            busy_reg  <= 1'b1;
            state_reg <= S_WAIT_DREQ;
`ifdef SCI_READ_TIMEOUT_EN
            to_cnt_reg <= '0;
`endif
          end
        end
        S_WAIT_DREQ: begin
          if (dreq_sync_reg) begin
            xcs_reg   <= 1'b0;
            si_reg    <= tx_reg[15];
            sck_reg   <= 1'b0;
            cnt_reg   <= HALF_RELOAD;
            state_reg <= S_CS_SETUP;
          end
`ifdef SCI_READ_TIMEOUT_EN
          else if (to_cnt_reg == TO_LAST) begin
            // Give up without ever touching XCS; o_rdata keeps the last good value.
            done_reg    <= 1'b1;
            timeout_reg <= 1'b1;
            state_reg   <= S_DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
`endif
        end
        S_CS_SETUP: begin
          if (cnt_reg == 8'd0) begin
            cnt_reg     <= HALF_RELOAD;
            bit_cnt_reg <= 5'd0;
            state_reg   <= S_SHIFT;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            cnt_reg <= HALF_RELOAD;
            if (!sck_reg) begin
              sck_reg <= 1'b1;
              if (bit_cnt_reg[4])
                rx_reg <= {rx_reg[14:0], i_SO};
            end else begin
              sck_reg <= 1'b0;
              if (bit_cnt_reg == 5'd31) begin
                state_reg <= S_CS_HOLD;
              end else begin
                // Zeros shift in behind the address, so SI is 0 for the read half.
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                tx_reg      <= {tx_reg[14:0], 1'b0};
                si_reg      <= tx_reg[14];
              end
            end
          end
        end
        S_CS_HOLD: begin
          if (cnt_reg == 8'd0) begin
            xcs_reg   <= 1'b1;
            si_reg    <= 1'b0;
            rdata_reg <= rx_reg;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          xcs_reg   <= 1'b1;
          sck_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign o_SI      = si_reg;
  assign o_SCK     = sck_reg;
  assign o_XCS     = xcs_reg;
  assign o_busy    = busy_reg;
  assign o_done    = done_reg;
  assign o_rdata   = rdata_reg;
  assign o_timeout = timeout_reg;

endmodule
